serial_rx_unpack: RTL and testbench

- Receive-side stage directly downstream of the parallel-load shift register that serialises calculator results.
- Consumes the serial bit stream (Dout, Dout_valid) at the rate set by the transmit-clock enable from the frequency divider.
- Rebuilds each 32-bit frame and splits it into operand A, operand B, ALU result, flags and opcode.
- Presents fields with a one-cycle valid strobe plus error/status, so a host model or display can check calculator output in-system.

---
 rtl/serial_rx_unpack.sv | 118 +++++++++++
 tb/tb_serial_rx_unpack.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_unpack.sv
// serial_rx_unpack: rebuilds serialised calculator result frames from the
// (Dout, Dout_valid) bit stream, sampled on rising edges of the clk_tx strobe,
// and splits each completed frame into operand, result, flag and opcode fields.
//
// state | meaning
// IDLE  | waiting for the first sample event with Dout_valid high
// SHIFT | collecting frame bits, one per sample event
// DONE  | one clk: publish the frame, bump frame_cnt, raise rx_valid next cycle
module serial_rx_unpack #(
  parameter int DATA_W    = 32,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_tx,
  input  logic              Dout_valid,
  input  logic              Dout,
  output logic [DATA_W-1:0] rx_word,
  output logic [7:0]        rx_op_a,
  output logic [7:0]        rx_op_b,
  output logic [7:0]        rx_result,
  output logic [3:0]        rx_flag,
  output logic [3:0]        rx_sel,
  output logic              rx_valid,
  output logic              rx_busy,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  logic              clk_tx_d;
  logic              se;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shift_in;
  logic [BW-1:0]     bit_cnt;

  // clk_tx is a level in the clk domain; only its rising edge samples data,
  // so a strobe held high for many clocks yields a single bit.
  assign se = clk_tx & ~clk_tx_d;

  // Next shift-register value with the current Dout inserted.
  always_comb begin
    shift_in = shreg;
    if (MSB_FIRST) shift_in = {shreg[DATA_W-2:0], Dout};
    else           shift_in = {Dout, shreg[DATA_W-1:1]};
  end

  // Receive FSM, strobe edge detector, frame publishing and status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      clk_tx_d  <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      rx_word   <= '0;
      frame_cnt <= '0;
      frame_err <= 1'b0;
      rx_valid  <= 1'b0;
    end else begin
      clk_tx_d <= clk_tx;
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (se && Dout_valid) begin
            shreg   <= shift_in;
            bit_cnt <= BW'(1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (se) begin
            if (Dout_valid) begin
              shreg   <= shift_in;
              bit_cnt <= bit_cnt + BW'(1);
              if (bit_cnt == LAST_IDX) state <= DONE;
            end else begin
              // Truncated frame: drop partial data, keep rx_word untouched.
              frame_err <= 1'b1;
              shreg     <= '0;
              bit_cnt   <= '0;
              state     <= IDLE;
            end
          end
        end
        DONE: begin
          rx_word   <= shreg;
          frame_cnt <= frame_cnt + CNT_W'(1);
          rx_valid  <= 1'b1;
          if (se && Dout_valid) begin
            // Next frame's first bit arrives while publishing; all old bits
            // shift out over the coming frame, so shifting shreg is safe.
            shreg   <= shift_in;
            bit_cnt <= BW'(1);
            state   <= SHIFT;
          end else begin
            bit_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_busy   = (state == SHIFT);
  assign rx_op_a   = rx_word[31:24];
  assign rx_op_b   = rx_word[23:16];
  assign rx_result = rx_word[15:8];
  assign rx_flag   = rx_word[7:4];
  assign rx_sel    = rx_word[3:0];

endmodule

// File: tb/tb_serial_rx_unpack.sv
// Bench for serial_rx_unpack: one MSB-first and one LSB-first instance share
// the same stimulus; per-instance queues hold the expected published frames.
module tb_serial_rx_unpack;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clk_tx = 1'b0;
  logic Dout_valid = 1'b0;
  logic Dout = 1'b0;

  logic [31:0] rx_word0, rx_word1;
  logic [7:0]  op_a0, op_b0, res0, op_a1, op_b1, res1;
  logic [3:0]  flag0, sel0, flag1, sel1;
  logic        valid0, busy0, err0, valid1, busy1, err1;
  logic [7:0]  cnt0, cnt1;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  cnt;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int bad = 0;
  logic [7:0] model_cnt = 8'd0;
  logic       model_err = 1'b0;

  always #5 clk = ~clk;

  serial_rx_unpack #(.DATA_W(32), .MSB_FIRST(1'b1), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .clk_tx(clk_tx), .Dout_valid(Dout_valid), .Dout(Dout),
    .rx_word(rx_word0), .rx_op_a(op_a0), .rx_op_b(op_b0), .rx_result(res0),
    .rx_flag(flag0), .rx_sel(sel0), .rx_valid(valid0), .rx_busy(busy0),
    .frame_err(err0), .frame_cnt(cnt0)
  );

  serial_rx_unpack #(.DATA_W(32), .MSB_FIRST(1'b0), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .clk_tx(clk_tx), .Dout_valid(Dout_valid), .Dout(Dout),
    .rx_word(rx_word1), .rx_op_a(op_a1), .rx_op_b(op_b1), .rx_result(res1),
    .rx_flag(flag1), .rx_sel(sel1), .rx_valid(valid1), .rx_busy(busy1),
    .frame_err(err1), .frame_cnt(cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // MSB-first instance monitor: fields are checked against slices of the
  // expected word.
  always @(negedge clk) begin
    if (valid0) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rx_valid0: got word 0x%08h expected no pulse", rx_word0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("word0", rx_word0, e.word);
        chk("op_a0", {24'd0, op_a0}, {24'd0, e.word[31:24]});
        chk("op_b0", {24'd0, op_b0}, {24'd0, e.word[23:16]});
        chk("result0", {24'd0, res0}, {24'd0, e.word[15:8]});
        chk("flag0", {28'd0, flag0}, {28'd0, e.word[7:4]});
        chk("sel0", {28'd0, sel0}, {28'd0, e.word[3:0]});
        chk("cnt0", {24'd0, cnt0}, {24'd0, e.cnt});
        chk("err0", {31'd0, err0}, {31'd0, e.err});
      end
    end
  end

  // LSB-first instance monitor.
  always @(negedge clk) begin
    if (valid1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rx_valid1: got word 0x%08h expected no pulse", rx_word1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("word1", rx_word1, e.word);
        chk("cnt1", {24'd0, cnt1}, {24'd0, e.cnt});
        chk("err1", {31'd0, err1}, {31'd0, e.err});
      end
    end
  end

  // One bit: clk_tx rises with Dout, stays high 1+hold clocks, then low for
  // gap clocks. With glitch set, Dout toggles whenever no rising edge is due.
  task automatic send_bit(input logic b, input int gap, input bit glitch, input int hold);
    Dout   = b;
    clk_tx = 1'b1;
    @(negedge clk);
    for (int k = 0; k < hold; k++) begin
      if (glitch) Dout = ~Dout;
      @(negedge clk);
    end
    clk_tx = 1'b0;
    for (int k = 0; k < gap; k++) begin
      if (glitch) Dout = ~Dout;
      @(negedge clk);
    end
  endtask

  // Sends nbits of w (MSB-first unless lsb is set); a full frame pushes the
  // expected result for both instances. Dout_valid is left high.
  task automatic send_frame(input logic [31:0] w, input bit lsb, input int gap,
                            input bit glitch, input int nbits, input int hold_idx);
    if (nbits == 32) begin
      exp_t e0, e1;
      model_cnt = model_cnt + 8'd1;
      e0.word = lsb ? bitrev(w) : w;
      e1.word = lsb ? w : bitrev(w);
      e0.cnt = model_cnt;
      e1.cnt = model_cnt;
      e0.err = model_err;
      e1.err = model_err;
      q0.push_back(e0);
      q1.push_back(e1);
    end
    Dout_valid = 1'b1;
    for (int i = 0; i < nbits; i++)
      send_bit(lsb ? w[i] : w[31-i], gap, glitch, (i == hold_idx) ? 9 : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_word", rx_word0, 32'd0);
    chk("reset_cnt", {24'd0, cnt0}, 32'd0);
    chk("reset_err", {31'd0, err0}, 32'd0);
    chk("reset_valid", {31'd0, valid0}, 32'd0);
    chk("reset_busy", {31'd0, busy0}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Dout_valid rising without a strobe edge must not start a frame.
    Dout_valid = 1'b1;
    Dout = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_start_busy", {31'd0, busy0}, 32'd0);
    Dout_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame, strobe every 4 clk.
    send_frame(32'h0708_0F01, 1'b0, 3, 1'b0, 32, -1);
    Dout_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Back-to-back frames with Dout_valid held high.
    send_frame(32'hA5C3_5A96, 1'b0, 3, 1'b0, 32, -1);
    send_frame(32'h1F1F_3E02, 1'b0, 3, 1'b0, 32, -1);
    Dout_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("b2b_cnt", {24'd0, cnt0}, 32'd3);

    // Truncated frame after 17 bits, then a good frame.
    send_frame(32'hDEAD_BEEF, 1'b0, 3, 1'b0, 17, -1);
    chk("trunc_busy", {31'd0, busy0}, 32'd1);
    Dout_valid = 1'b0;
    send_bit(1'b0, 3, 1'b0, 0);
    model_err = 1'b1;
    chk("trunc_err0", {31'd0, err0}, 32'd1);
    chk("trunc_err1", {31'd0, err1}, 32'd1);
    chk("trunc_idle", {31'd0, busy0}, 32'd0);
    chk("trunc_word_kept", rx_word0, 32'h1F1F_3E02);
    send_frame(32'h0000_00FF, 1'b0, 3, 1'b0, 32, -1);
    Dout_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Glitches between strobe edges plus one bit with clk_tx held high 10 clk.
    send_frame(32'h5A5A_F00F, 1'b0, 3, 1'b1, 32, 5);
    Dout_valid = 1'b0;
    repeat (6) @(negedge clk);

    // LSB-first bit order.
    send_frame(32'h8000_0001, 1'b1, 3, 1'b0, 32, -1);
    Dout_valid = 1'b0;
    repeat (6) @(negedge clk);
    send_frame(32'h0000_000D, 1'b1, 3, 1'b0, 32, -1);
    Dout_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Asynchronous reset at bit 10 of a frame.
    send_frame(32'h1234_5678, 1'b0, 3, 1'b0, 10, -1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_word", rx_word0, 32'd0);
    chk("async_cnt", {24'd0, cnt0}, 32'd0);
    chk("async_err", {31'd0, err0}, 32'd0);
    chk("async_busy", {31'd0, busy0}, 32'd0);
    chk("async_word1", rx_word1, 32'd0);
    Dout_valid = 1'b0;
    clk_tx = 1'b0;
    model_cnt = 8'd0;
    model_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Fresh frame with the divider bypassed (strobe every other clk).
    send_frame(32'h1234_5678, 1'b0, 1, 1'b0, 32, -1);
    Dout_valid = 1'b0;
    repeat (10) @(negedge clk);

    chk("pending0", q0.size(), 32'd0);
    chk("pending1", q1.size(), 32'd0);
    chk("final_cnt", {24'd0, cnt0}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
